// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_CH byte-stream requesters.
// Each granted packet is sent as a channel-ID header byte followed by its payload bytes.
module uart_tx_arbiter #(
   parameter int         NUM_CH  = 4,
   parameter logic [7:0] HDR_TAG = 8'h2A,
   parameter int         MAX_LEN = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         in_valid,
   input  logic [8*NUM_CH-1:0]       in_data,
   input  logic [NUM_CH-1:0]         in_last,
   output logic [NUM_CH-1:0]         in_ready,
   output logic                      tx_start,
   output logic [7:0]                tx_data,
   input  logic                      tx_busy,
   output logic [$clog2(NUM_CH)-1:0] grant_ch,
   output logic                      pkt_active,
   output logic                      err_overlen
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int TAG_W = 8 - CH_W;
   localparam int CNT_W = $clog2(MAX_LEN + 1);
   localparam logic [TAG_W-1:0] TAG     = HDR_TAG[TAG_W-1:0];
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ACK   = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_LOAD  = 3'd4;

   logic [2:0]      state;
   logic [CH_W-1:0] last_ch;
   logic [CNT_W-1:0] byte_cnt;
   logic            cur_last;
   logic [CH_W-1:0] pick;
   logic            pop;
   logic [7:0]      sel_data;
   logic            sel_last;

   // Nearest requester after last_ch wins; last_ch itself has lowest priority.
   function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                               input logic [CH_W-1:0]   last);
      logic [CH_W-1:0] idx;
      rr_pick = last;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = last + CH_W'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   assign pick     = rr_pick(in_valid, last_ch);
   assign sel_data = in_data[8*int'(grant_ch) +: 8];
   assign sel_last = in_last[grant_ch];
   assign pop      = (state == S_LOAD) && in_valid[grant_ch];
   assign tx_start = (state == S_START);

   always_comb begin
      in_ready = '0;
      if (state == S_LOAD) in_ready[grant_ch] = in_valid[grant_ch];
   end

   // byte_cnt == 0 in DONE marks the header; payload bytes count 1..MAX_LEN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         last_ch     <= CH_W'(NUM_CH - 1);
         grant_ch    <= '0;
         tx_data     <= '0;
         byte_cnt    <= '0;
         cur_last    <= 1'b0;
         pkt_active  <= 1'b0;
         err_overlen <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|in_valid) begin
                  grant_ch   <= pick;
                  tx_data    <= {TAG, pick};
                  byte_cnt   <= '0;
                  cur_last   <= 1'b0;
                  pkt_active <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: state <= S_ACK;
            S_ACK: begin
               if (tx_busy) state <= S_DONE;
            end
            S_DONE: begin
               if (!tx_busy) begin
                  if (byte_cnt == '0) begin
                     state <= S_LOAD;
                  end else if (cur_last || byte_cnt == CNT_MAX) begin
                     pkt_active <= 1'b0;
                     last_ch    <= grant_ch;
                     state      <= S_IDLE;
                     if (!cur_last) err_overlen <= 1'b1;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (pop) begin
                  tx_data  <= sel_data;
                  cur_last <= sel_last;
                  byte_cnt <= byte_cnt + 1'b1;
                  state    <= S_START;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-channel source queues, a uart_tx busy model that logs
// every started byte, a table of round-robin vectors and directed multi-cycle sequences.
module tb_uart_tx_arbiter;

   localparam int NUM_CH  = 4;
   localparam int MAX_LEN = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  in_valid = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_last = '0;
   logic [3:0]  in_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic [1:0]  grant_ch;
   logic        pkt_active;
   logic        err_overlen;

   uart_tx_arbiter #(.NUM_CH(NUM_CH), .HDR_TAG(8'h2A), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant_ch(grant_ch), .pkt_active(pkt_active), .err_overlen(err_overlen)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] gap;
      logic       last;
      logic [7:0] data;
   } entry_t;

   typedef struct {
      logic [3:0]  mask;
      logic [63:0] exp;
      int          n;
   } vec_t;

   entry_t     chq[NUM_CH][$];
   logic [7:0] log_q[$];
   int         pops[NUM_CH];
   int         gap_cnt[NUM_CH];
   int         bdly = 1;
   int         bhold = 10;
   int         cnt = 0;
   int         hold = 0;
   logic       prev_start = 1'b0;
   logic [7:0] cur_byte = '0;
   int         proto_viol = 0;
   logic [3:0] rdy_q = '0;
   int         n_chk = 0;
   int         n_fail = 0;

   always @(posedge clk) rdy_q <= in_ready;

   // Source queues, pop bookkeeping and the uart_tx busy model all advance on the falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < NUM_CH; k++)
         if (gap_cnt[k] > 0) gap_cnt[k]--;
      for (int k = 0; k < NUM_CH; k++) begin
         if (rdy_q[k]) begin
            if (chq[k].size() > 0) begin
               void'(chq[k].pop_front());
               pops[k]++;
               if (chq[k].size() > 0) gap_cnt[k] = int'(chq[k][0].gap);
            end else begin
               proto_viol++;
            end
         end
      end
      if ((in_ready & ~(4'b0001 << grant_ch)) != 4'b0000) proto_viol++;
      for (int k = 0; k < NUM_CH; k++) begin
         if (chq[k].size() > 0 && gap_cnt[k] == 0) begin
            in_valid[k]       = 1'b1;
            in_data[8*k +: 8] = chq[k][0].data;
            in_last[k]        = chq[k][0].last;
         end else begin
            in_valid[k]       = 1'b0;
            in_data[8*k +: 8] = 8'h00;
            in_last[k]        = 1'b0;
         end
      end
      if (rst) begin
         tx_busy    = 1'b0;
         cnt        = 0;
         hold       = 0;
         prev_start = 1'b0;
      end else begin
         if (tx_start) begin
            log_q.push_back(tx_data);
            cur_byte = tx_data;
            if (prev_start) proto_viol++;
            cnt = bdly;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               tx_busy = 1'b1;
               hold    = bhold;
            end
         end else if (tx_busy) begin
            if (tx_data != cur_byte) proto_viol++;
            hold--;
            if (hold == 0) tx_busy = 1'b0;
         end
         prev_start = tx_start;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int ch, input logic [7:0] data, input logic last, input logic [7:0] gap);
      entry_t e;
      e.gap  = gap;
      e.last = last;
      e.data = data;
      chq[ch].push_back(e);
   endtask

   task automatic wait_log(input string name, input int n);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         @(negedge clk);
         #1;
         ok = (log_q.size() >= n);
      end
      check({name, "_wait_log"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_done(input string name, input int n);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         @(negedge clk);
         #1;
         ok = (log_q.size() >= n) && !pkt_active && !tx_busy;
         for (int k = 0; k < NUM_CH; k++)
            if (chq[k].size() != 0) ok = 1'b0;
      end
      check({name, "_wait_done"}, 64'(ok), 64'd1);
   endtask

   task automatic check_stream(input string name, input logic [63:0] exp, input int n);
      logic [7:0] a;
      check({name, "_len"}, 64'(log_q.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         a = (i < log_q.size()) ? log_q[i] : 8'h00;
         check($sformatf("%s_byte%0d", name, i), 64'(a), 64'(exp[8*(n-1-i) +: 8]));
      end
      log_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[5];
      int   p;
      vt[0] = '{4'b1111, 64'hA8_00_A9_01_AA_02_AB_03, 8};
      vt[1] = '{4'b0101, 64'h0000_0000_A8_10_AA_12, 4};
      vt[2] = '{4'b1010, 64'h0000_0000_AB_23_A9_21, 4};
      vt[3] = '{4'b0001, 64'h0000_0000_0000_A8_30, 2};
      vt[4] = '{4'b1100, 64'h0000_0000_AA_42_AB_43, 4};
      for (int k = 0; k < NUM_CH; k++) begin
         pops[k]    = 0;
         gap_cnt[k] = 0;
      end

      // Reset state, with every channel already requesting
      #7;
      check("reset_outputs", 64'({in_ready, tx_start, tx_data, grant_ch, pkt_active, err_overlen}), 64'd0);

      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < NUM_CH; k++)
            if (vt[v].mask[k]) push(k, 8'(v*16 + k), 1'b1, 8'd0);
         if (v == 0) begin
            repeat (2) @(negedge clk);
            #2 rst = 1'b0;
         end
         wait_done($sformatf("vec%0d", v), vt[v].n);
         check_stream($sformatf("vec%0d", v), vt[v].exp, vt[v].n);
      end

      // Single two-byte packet on ch1
      p = pops[1];
      push(1, 8'h11, 1'b0, 8'd0);
      push(1, 8'h22, 1'b1, 8'd0);
      wait_log("single", 3);
      check("single_active_last_byte", 64'(pkt_active), 64'd1);
      wait_done("single", 3);
      check("single_pops", 64'(pops[1] - p), 64'd2);
      check_stream("single", 64'hA9_11_22, 3);

      // Grant lock: ch2 stalls mid-packet while ch0 waits
      push(2, 8'h61, 1'b0, 8'd0);
      push(2, 8'h62, 1'b0, 8'd20);
      push(2, 8'h63, 1'b1, 8'd0);
      push(0, 8'h55, 1'b1, 8'd0);
      wait_log("lock", 2);
      repeat (15) @(negedge clk);
      #1;
      check("lock_grant_held", 64'(grant_ch), 64'd2);
      check("lock_no_ready", 64'(in_ready), 64'd0);
      check("lock_active", 64'(pkt_active), 64'd1);
      wait_done("lock", 6);
      check_stream("lock", 64'hAA_61_62_63_A8_55, 6);

      // Overlength truncation at MAX_LEN
      check("overlen_clear_before", 64'(err_overlen), 64'd0);
      for (int i = 1; i <= 6; i++) push(3, 8'(8'h70 + i), (i == 6), 8'd0);
      wait_done("overlen", 8);
      check_stream("overlen", 64'hAB_71_72_73_74_AB_75_76, 8);
      check("overlen_flag", 64'(err_overlen), 64'd1);

      // Slow uart: busy rises 3 cycles after start, holds 200
      bdly  = 3;
      bhold = 200;
      push(0, 8'h5A, 1'b1, 8'd0);
      wait_done("slow", 2);
      check_stream("slow", 64'hA8_5A, 2);
      check("slow_overlen_sticky", 64'(err_overlen), 64'd1);
      check("slow_protocol", 64'(proto_viol), 64'd0);

      // Reset while waiting for acceptance of payload byte 2
      bhold = 10;
      p = pops[1];
      push(1, 8'hB1, 1'b0, 8'd0);
      push(1, 8'hB2, 1'b0, 8'd0);
      push(1, 8'hB3, 1'b1, 8'd0);
      wait_log("rst_mid", 3);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_outputs",
            64'({in_ready, tx_start, tx_data, grant_ch, pkt_active, err_overlen}), 64'd0);
      check("rst_mid_pops_before", 64'(pops[1] - p), 64'd2);
      repeat (2) @(negedge clk);
      log_q.delete();
      #2 rst = 1'b0;
      wait_done("rst_mid", 2);
      check_stream("rst_mid", 64'hA9_B3, 2);
      check("rst_mid_pops_after", 64'(pops[1] - p), 64'd3);
      check("protocol_total", 64'(proto_viol), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
